// File: rtl/gcd_operand_packer_pkg.sv
// Shared types and constants for the GCD operand packer.
// Also used by the GCD engine and its bench.
package gcd_operand_packer_pkg;

  localparam int OPERAND_WIDTH = 16;
  localparam int REQ_WIDTH     = 2 * OPERAND_WIDTH;

  typedef enum logic {
    GET_A = 1'b0,
    GET_B = 1'b1
  } pack_state_e;

  // First operand goes in the upper half of a request.
  function automatic logic [REQ_WIDTH-1:0] pack_pair(
    input logic [OPERAND_WIDTH-1:0] a,
    input logic [OPERAND_WIDTH-1:0] b
  );
    return {a, b};
  endfunction

endpackage

// File: rtl/gcd_operand_packer_pair_fifo.sv
// Circular pair buffer with wrap-bit pointers.
// Head reads as zero whenever the buffer is empty.
module pair_fifo
  import gcd_operand_packer_pkg::*;
#(
  parameter int WIDTH = REQ_WIDTH,
  parameter int DEPTH = 2,
  parameter int AW    = $clog2(DEPTH),
  parameter int PW    = AW + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head,
  output logic [PW-1:0]    level
);

  logic [PW-1:0]    wptr;
  logic [PW-1:0]    rptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW]) &&
                 (wptr[AW-1:0] == rptr[AW-1:0]);
  assign level = wptr - rptr;

  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;

  assign head = empty ? '0 : mem[rptr[AW-1:0]];

  // Pointer update; flush rewinds both to zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr <= '0;
      rptr <= '0;
    end else if (flush) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
    end
  end

  // Storage write; contents are don't-care while empty.
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/gcd_operand_packer.sv
// Pairs serial operands as {a, b} and queues them
// as requests for the GCD engine.
module gcd_operand_packer
  import gcd_operand_packer_pkg::*;
#(
  parameter int WIDTH = OPERAND_WIDTH,
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flush,
  input  logic [WIDTH-1:0]   in_data,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [2*WIDTH-1:0] out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [CNT_W-1:0]   pairs_sent,
  output logic               half_pending
);

  localparam int PW = $clog2(DEPTH) + 1;

  pack_state_e      state_q;
  pack_state_e      state_d;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] a_d;
  logic             rdy_q;
  logic             rdy_d;
  logic [CNT_W-1:0] cnt_q;

  logic               fire_in;
  logic               push;
  logic               pop;
  logic               f_full;
  logic               f_empty;
  logic [PW-1:0]      f_level;
  logic [PW-1:0]      lvl_nx;
  logic [2*WIDTH-1:0] pair;

  assign in_ready     = rdy_q;
  assign half_pending = (state_q == GET_B);
  assign out_valid    = !f_empty;
  assign pairs_sent   = cnt_q;

  assign fire_in = in_valid && rdy_q;
  assign push    = fire_in && (state_q == GET_B) &&
                   !f_full && !flush;
  assign pop     = out_valid && out_ready && !flush;
  assign lvl_nx  = f_level + PW'(push) - PW'(pop);

  if (WIDTH == OPERAND_WIDTH) begin : g_pack
    assign pair = pack_pair(a_q, in_data);
  end else begin : g_cat
    assign pair = {a_q, in_data};
  end

  pair_fifo #(
    .WIDTH (2*WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .push      (push),
    .push_data (pair),
    .pop       (pop),
    .full      (f_full),
    .empty     (f_empty),
    .head      (out_data),
    .level     (f_level)
  );

  // Next state, a capture and registered ready.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    unique case (state_q)
      GET_A: begin
        if (fire_in) begin
          a_d     = in_data;
          state_d = GET_B;
        end
      end
      GET_B: begin
        if (fire_in) state_d = GET_A;
      end
      default: state_d = GET_A;
    endcase
    if (flush) begin
      state_d = GET_A;
      a_d     = '0;
    end
    rdy_d = (state_d == GET_A) ||
            (lvl_nx != PW'(DEPTH));
  end

  // FSM, a operand and ready registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= GET_A;
      a_q     <= '0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      rdy_q   <= rdy_d;
    end
  end

  // Issued-pair counter, wraps naturally.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else if (flush) begin
      cnt_q <= '0;
    end else if (pop) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule
